// File: rtl/count_mon_pkg.sv
// Shared types and defaults for the count event monitor: FSM states, event codes,
// the queued event record and the default alarm thresholds.
package count_mon_pkg;

    typedef enum logic [1:0] {
        ST_UNPRIMED = 2'd0,
        ST_NORMAL   = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } mon_state_t;

    typedef enum logic [2:0] {
        EVT_NONE       = 3'd0,
        EVT_WRAP_UP    = 3'd1,
        EVT_WRAP_DN    = 3'd2,
        EVT_ENTER_HIGH = 3'd3,
        EVT_ENTER_LOW  = 3'd4,
        EVT_EXIT_ALARM = 3'd5,
        EVT_JUMP       = 3'd6
    } evt_code_t;

    localparam logic [7:0] DEF_HI_THRESH = 8'd200;
    localparam logic [7:0] DEF_LO_THRESH = 8'd50;
    localparam logic [7:0] DEF_HYST      = 8'd8;
    localparam int         DEF_EVQ_DEPTH = 2;
    localparam int         EVT_W         = 11;

    typedef struct packed {
        evt_code_t  code;
        logic [7:0] count;
    } evt_t;

    // Zone entered from UNPRIMED or NORMAL; hysteresis only applies on the way out.
    function automatic mon_state_t entry_zone(input logic [7:0] value,
                                              input logic [7:0] hi,
                                              input logic [7:0] lo);
        if (value >= hi)      return ST_HIGH;
        else if (value <= lo) return ST_LOW;
        else                  return ST_NORMAL;
    endfunction

endpackage

// File: rtl/count_evt_fifo.sv
// Small power-of-two event queue with registered storage, full/empty flags and
// simultaneous push/pop (a push is accepted on a full queue when a pop happens too).
module count_evt_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Stale entries are masked here so the head reads as zero whenever the queue is empty.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: pointer/count registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; empty-masking on pop_data makes its contents irrelevant after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/count_event_monitor.sv
// Watches a sampled up/down count, classifies each step, tracks a hysteretic
// HIGH/LOW alarm FSM and queues one event per sample for a ready/valid consumer.
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter logic [7:0] HI_THRESH = DEF_HI_THRESH,
    parameter logic [7:0] LO_THRESH = DEF_LO_THRESH,
    parameter logic [7:0] HYST      = DEF_HYST,
    parameter int         EVQ_DEPTH = DEF_EVQ_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cnt_in,
    input  logic       cnt_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_code,
    output logic [7:0] evt_count,
    output logic       alarm,
    output logic       evt_lost
);

    generate
        if (int'(LO_THRESH) + int'(HYST) >= int'(HI_THRESH) - int'(HYST)) begin : g_bad_thresh
            $error("count_event_monitor: LO_THRESH+HYST must be below HI_THRESH-HYST");
        end
        if ((EVQ_DEPTH < 2) || ((EVQ_DEPTH & (EVQ_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("count_event_monitor: EVQ_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    localparam logic [7:0] HI_EXIT = HI_THRESH - HYST;
    localparam logic [7:0] LO_EXIT = LO_THRESH + HYST;

    mon_state_t state;
    mon_state_t next_state;
    logic [7:0] prev;
    evt_code_t  new_code;
    evt_t       new_evt;
    evt_t       head;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        new_code   = EVT_NONE;

        unique case (state)
            ST_UNPRIMED,
            ST_NORMAL: next_state = entry_zone(cnt_in, HI_THRESH, LO_THRESH);
            ST_HIGH: begin
                if (cnt_in <= LO_THRESH)   next_state = ST_LOW;
                else if (cnt_in < HI_EXIT) next_state = ST_NORMAL;
            end
            ST_LOW: begin
                if (cnt_in >= HI_THRESH)   next_state = ST_HIGH;
                else if (cnt_in > LO_EXIT) next_state = ST_NORMAL;
            end
            default: next_state = ST_UNPRIMED;
        endcase

        // Wrap beats jump beats FSM transition; the first sample only primes.
        if (state != ST_UNPRIMED) begin
            if (prev == 8'hFF && cnt_in == 8'h00) begin
                new_code = EVT_WRAP_UP;
            end else if (prev == 8'h00 && cnt_in == 8'hFF) begin
                new_code = EVT_WRAP_DN;
            end else if (cnt_in != prev && cnt_in != (prev + 8'd1) && cnt_in != (prev - 8'd1)) begin
                new_code = EVT_JUMP;
            end else if (next_state != state) begin
                case (next_state)
                    ST_HIGH: new_code = EVT_ENTER_HIGH;
                    ST_LOW:  new_code = EVT_ENTER_LOW;
                    default: new_code = EVT_EXIT_ALARM;
                endcase
            end
        end
    end

    assign push    = cnt_en && (new_code != EVT_NONE);
    assign pop     = evt_valid && evt_ready;
    assign new_evt = '{code: new_code, count: cnt_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_UNPRIMED;
            prev     <= '0;
            alarm    <= 1'b0;
            evt_lost <= 1'b0;
        end else begin
            if (cnt_en) begin
                state <= next_state;
                prev  <= cnt_in;
                alarm <= (next_state == ST_HIGH) || (next_state == ST_LOW);
            end
            if (push && full && !pop) evt_lost <= 1'b1;
        end
    end

    count_evt_fifo #(
        .DEPTH (EVQ_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (new_evt),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign evt_valid = !empty;
    assign evt_code  = head.code;
    assign evt_count = head.count;

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: directed vector table, hand-written
// queue/reset sequences, then randomized samples against a behavioural model.
module tb_count_event_monitor;

    localparam int HI    = 200;
    localparam int LO    = 50;
    localparam int HYST  = 8;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cnt_in;
    logic       cnt_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [7:0] evt_count;
    logic       alarm;
    logic       evt_lost;

    always #5 clk = ~clk;

    count_event_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .cnt_en    (cnt_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_count (evt_count),
        .alarm     (alarm),
        .evt_lost  (evt_lost)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: alarm zone, last sample and an event queue.
    typedef enum int {Z_NORMAL, Z_HIGH, Z_LOW} zone_e;

    bit    m_primed;
    int    m_prev;
    zone_e m_zone;
    bit    m_lost;
    int    q_code[$];
    int    q_count[$];

    function automatic zone_e next_zone(input zone_e z, input int c);
        case (z)
            Z_HIGH:  return (c <= LO) ? Z_LOW  : (c < HI - HYST) ? Z_NORMAL : Z_HIGH;
            Z_LOW:   return (c >= HI) ? Z_HIGH : (c > LO + HYST) ? Z_NORMAL : Z_LOW;
            default: return (c >= HI) ? Z_HIGH : (c <= LO) ? Z_LOW : Z_NORMAL;
        endcase
    endfunction

    task automatic model_reset();
        m_primed = 1'b0;
        m_prev   = 0;
        m_zone   = Z_NORMAL;
        m_lost   = 1'b0;
        q_code.delete();
        q_count.delete();
    endtask

    task automatic model_step(input bit en, input int c, input bit rdy);
        int    d;
        int    code;
        zone_e nz;
        if (rdy && q_code.size() > 0) begin
            void'(q_code.pop_front());
            void'(q_count.pop_front());
        end
        if (en) begin
            nz = next_zone(m_primed ? m_zone : Z_NORMAL, c);
            if (m_primed) begin
                d    = (c - m_prev + 256) % 256;
                code = 0;
                if (d == 1 && c == 0)        code = 1;
                else if (d == 255 && c == 255) code = 2;
                else if (d > 1 && d < 255)   code = 6;
                else if (nz != m_zone)       code = (nz == Z_HIGH) ? 3 : (nz == Z_LOW) ? 4 : 5;
                if (code != 0) begin
                    if (q_code.size() < DEPTH) begin
                        q_code.push_back(code);
                        q_count.push_back(c);
                    end else begin
                        m_lost = 1'b1;
                    end
                end
            end
            m_primed = 1'b1;
            m_zone   = nz;
            m_prev   = c;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, evt_valid, q_code.size() > 0);
        if (q_code.size() > 0) begin
            check({tag, "_code"}, evt_code, q_code[0]);
            check({tag, "_count"}, evt_count, q_count[0]);
        end
        check({tag, "_alarm"}, alarm, m_primed && (m_zone != Z_NORMAL));
        check({tag, "_lost"}, evt_lost, m_lost);
    endtask

    // Drive at the falling edge, sample the DUT at the next falling edge.
    task automatic step(input bit en, input logic [7:0] c, input bit rdy);
        cnt_en    = en;
        cnt_in    = c;
        evt_ready = rdy;
        @(posedge clk);
        model_step(en, int'(c), rdy);
        @(negedge clk);
    endtask

    // Reset is dropped mid-cycle so the outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        check({tag, "_rst_valid"}, evt_valid, 0);
        check({tag, "_rst_code"}, evt_code, 0);
        check({tag, "_rst_count"}, evt_count, 0);
        check({tag, "_rst_alarm"}, alarm, 0);
        check({tag, "_rst_lost"}, evt_lost, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] cnt;
        bit         rdy;
        bit         valid;
        logic [2:0] code;
        logic [7:0] count;
        bit         alarm;
        bit         lost;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input bit en, input int cnt, input bit rdy,
                                input bit valid, input int code, input int count,
                                input bit alm, input bit lost);
        vec_t v;
        v.rst   = rst;
        v.en    = en;
        v.cnt   = cnt[7:0];
        v.rdy   = rdy;
        v.valid = valid;
        v.code  = code[2:0];
        v.count = count[7:0];
        v.alarm = alm;
        v.lost  = lost;
        return v;
    endfunction

    initial begin
        vec_t       v;
        logic [7:0] last;
        logic [7:0] c;
        int         r;
        string      tag;

        reset     = 1'b0;
        cnt_en    = 1'b0;
        cnt_in    = '0;
        evt_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // Step into LOW at 50 (stepping so JUMP does not mask the FSM event), then climb out at 59.
        vecs.push_back(mk(1, 1, 52, 1,  0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 51, 1,  0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 50, 1,  1, 4, 50, 1, 0));
        for (int k = 51; k <= 58; k++) vecs.push_back(mk(0, 1, k, 1,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 59, 1,  1, 5, 59, 0, 0));
        vecs.push_back(mk(0, 0, 200, 1, 0, 0, 0,  0, 0));
        // Prime 100, jump to 30: JUMP only, FSM lands in LOW.
        vecs.push_back(mk(1, 1, 100, 1, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 30, 1,  1, 6, 30, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0,  1, 0));
        // Prime FE (HIGH, no event), FF, wrap up to 00 (HIGH->LOW), wrap down to FF (LOW->HIGH).
        vecs.push_back(mk(1, 1, 254, 1, 0, 0, 0,   1, 0));
        vecs.push_back(mk(0, 1, 255, 1, 0, 0, 0,   1, 0));
        vecs.push_back(mk(0, 1, 0, 1,   1, 1, 0,   1, 0));
        vecs.push_back(mk(0, 1, 255, 1, 1, 2, 255, 1, 0));
        // Stalled consumer: three events into a two-entry queue, then drain exactly two.
        vecs.push_back(mk(1, 1, 100, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 30, 0,  1, 6, 30,  1, 0));
        vecs.push_back(mk(0, 1, 31, 0,  1, 6, 30,  1, 0));
        vecs.push_back(mk(0, 1, 100, 0, 1, 6, 30,  0, 0));
        vecs.push_back(mk(0, 1, 10, 0,  1, 6, 30,  1, 1));
        vecs.push_back(mk(0, 0, 10, 1,  1, 6, 100, 1, 1));
        vecs.push_back(mk(0, 0, 10, 1,  0, 0, 0,   1, 1));
        vecs.push_back(mk(0, 0, 10, 1,  0, 0, 0,   1, 1));

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.rst) do_reset($sformatf("vec%0d", i));
            step(v.en, v.cnt, v.rdy);
            check($sformatf("vec%0d_valid", i), evt_valid, v.valid);
            if (v.valid) begin
                check($sformatf("vec%0d_code", i), evt_code, v.code);
                check($sformatf("vec%0d_count", i), evt_count, v.count);
            end
            check($sformatf("vec%0d_alarm", i), alarm, v.alarm);
            check($sformatf("vec%0d_lost", i), evt_lost, v.lost);
        end

        // Full queue with simultaneous push and pop: nothing is dropped.
        do_reset("full_pp");
        step(1, 8'd100, 0);
        step(1, 8'd30, 0);
        step(1, 8'd100, 0);
        step(1, 8'd10, 1);
        check("full_pp_head_code", evt_code, 6);
        check("full_pp_head_count", evt_count, 100);
        check("full_pp_lost", evt_lost, 0);
        step(0, 8'd10, 1);
        check("full_pp_second_count", evt_count, 10);
        check("full_pp_second_valid", evt_valid, 1);
        step(0, 8'd10, 1);
        check("full_pp_drained", evt_valid, 0);

        // Reset mid-burst with a full queue and the lost flag set.
        do_reset("burst");
        step(1, 8'd100, 0);
        step(1, 8'd30, 0);
        step(1, 8'd100, 0);
        step(1, 8'd10, 0);
        check("burst_pre_valid", evt_valid, 1);
        check("burst_pre_lost", evt_lost, 1);
        do_reset("burst");
        step(1, 8'd30, 1);
        check("burst_prime_valid", evt_valid, 0);
        check("burst_prime_alarm", alarm, 1);
        step(1, 8'd31, 1);
        check("burst_next_valid", evt_valid, 0);

        // Randomized samples biased toward steps, wraps and threshold neighbourhoods.
        do_reset("rand");
        last = 8'd100;
        for (int i = 0; i < 3000; i++) begin
            tag = $sformatf("rand%0d", i);
            if ($urandom_range(0, 399) == 0) begin
                do_reset(tag);
                continue;
            end
            r = $urandom_range(0, 7);
            case (r)
                0, 1, 2, 3: c = last + 8'($urandom_range(0, 2)) - 8'd1;
                4:          c = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                5:          c = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(40, 70))
                                                            : 8'($urandom_range(185, 210));
                default:    c = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, c, $urandom_range(0, 1) == 1);
            check_model(tag);
            last = c;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
